// File: rtl/mips_cpu_writeback_if.sv
// rtl/mips_cpu_writeback_if.sv - producer/memory/register-file bundle for the write-back unit
interface mips_cpu_writeback_if;
  // execute stage: ALU result
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_result;

  // memory stage: load issue
  logic        load_valid;
  logic [4:0]  load_dest;
  logic [2:0]  load_op;
  logic [1:0]  load_offset;
  logic [31:0] load_merge;

  // memory read data return
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;

  // status back to the pipeline and hazard logic
  logic        stall;
  logic        pending_valid;
  logic [4:0]  pending_dest;

  // register-file write port
  logic        writeEnable;
  logic [4:0]  writeAddress;
  logic [31:0] dataIn;

  // pipeline/memory side that feeds the unit and observes it
  modport master (
    output alu_valid, alu_dest, alu_result,
    output load_valid, load_dest, load_op, load_offset, load_merge,
    output mem_readdatavalid, mem_readdata,
    input  stall, pending_valid, pending_dest,
    input  writeEnable, writeAddress, dataIn
  );

  // the write-back unit itself
  modport slave (
    input  alu_valid, alu_dest, alu_result,
    input  load_valid, load_dest, load_op, load_offset, load_merge,
    input  mem_readdatavalid, mem_readdata,
    output stall, pending_valid, pending_dest,
    output writeEnable, writeAddress, dataIn
  );
endinterface

// File: rtl/mips_cpu_writeback.sv
// rtl/mips_cpu_writeback.sv - register-file write-back unit; LWL/LWR merge built when MIPS_CPU_WRITEBACK_UNALIGNED_EN is defined
module mips_cpu_writeback (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_writeback_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
  localparam logic [2:0] OP_LWL = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;
`endif

  state_t      state_q, state_d;

  // fields of the single outstanding load
  logic [4:0]  cap_dest_q, cap_dest_d;
  logic [2:0]  cap_op_q,   cap_op_d;
  logic [1:0]  cap_off_q,  cap_off_d;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
  logic [31:0] cap_merge_q, cap_merge_d;
`endif

  // register-file write port registers
  logic        we_q,    we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        alu_accept;
  logic        load_accept;
  logic        load_done;
  logic [31:0] load_data;

  // Extracts the addressed byte/halfword from the aligned word and extends it;
  // the unaligned-word ops splice memory bytes into the old register value.
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
  function automatic logic [31:0] fmt_load(input logic [2:0]  op,
                                           input logic [1:0]  off,
                                           input logic [31:0] d,
                                           input logic [31:0] merge);
    logic [4:0]  lo_sh;
    logic [4:0]  hi_sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lo_sh = {off, 3'b000};
    hi_sh = {2'd3 - off, 3'b000};
    b     = 8'(d >> lo_sh);
    h     = off[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      // memory supplies the upper bytes, register keeps the low 8*(3-b) bits
      OP_LWL:  r = (d << hi_sh) | (merge & ((32'd1 << hi_sh) - 32'd1));
      // memory supplies the lower bytes, register keeps the high 8*b bits
      OP_LWR:  r = (d >> lo_sh) | (merge & ~(32'hFFFF_FFFF >> lo_sh));
      default: r = d;
    endcase
    return r;
  endfunction
`else
  function automatic logic [31:0] fmt_load(input logic [2:0]  op,
                                           input logic [1:0]  off,
                                           input logic [31:0] d);
    logic [4:0]  lo_sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lo_sh = {off, 3'b000};
    b     = 8'(d >> lo_sh);
    h     = off[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      // LW, 111, and the unaligned ops all return the word unchanged
      default: r = d;
    endcase
    return r;
  endfunction
`endif

  // Handshake qualifiers: inputs are only looked at in the state that uses them
  always_comb begin
    alu_accept  = (state_q == IDLE) && bus.alu_valid;
    load_accept = (state_q == IDLE) && bus.load_valid;
    load_done   = (state_q == WAIT_LOAD) && bus.mem_readdatavalid;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
    load_data   = fmt_load(cap_op_q, cap_off_q, bus.mem_readdata, cap_merge_q);
`else
    load_data   = fmt_load(cap_op_q, cap_off_q, bus.mem_readdata);
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one load in flight, released by the memory data strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.load_valid)        state_d = WAIT_LOAD;
      WAIT_LOAD: if (bus.mem_readdatavalid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: status derived from registered state, so it is glitch-free
  always_comb begin
    bus.stall         = 1'b0;
    bus.pending_valid = 1'b0;
    bus.pending_dest  = 5'd0;
    if (state_q == WAIT_LOAD) begin
      bus.stall         = 1'b1;
      bus.pending_valid = 1'b1;
      bus.pending_dest  = cap_dest_q;
    end
  end

  // Capture next-state: the load's fields are latched only when it is accepted
  always_comb begin
    cap_dest_d  = cap_dest_q;
    cap_op_d    = cap_op_q;
    cap_off_d   = cap_off_q;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
    cap_merge_d = cap_merge_q;
`endif
    if (load_accept) begin
      cap_dest_d  = bus.load_dest;
      cap_op_d    = bus.load_op;
      cap_off_d   = bus.load_offset;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
      cap_merge_d = bus.load_merge;
`endif
    end
  end

  // Capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_dest_q  <= 5'd0;
      cap_op_q    <= 3'd0;
      cap_off_q   <= 2'd0;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
      cap_merge_q <= 32'd0;
`endif
    end else begin
      cap_dest_q  <= cap_dest_d;
      cap_op_q    <= cap_op_d;
      cap_off_q   <= cap_off_d;
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
      cap_merge_q <= cap_merge_d;
`endif
    end
  end

  // Write-port next-state: ALU and load commits live in different states so
  // they never collide; writes to $0 are dropped and the port keeps its values
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_accept && (bus.alu_dest != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_dest;
      wdata_d = bus.alu_result;
    end else if (load_done && (cap_dest_q != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = cap_dest_q;
      wdata_d = load_data;
    end
  end

  // Write-port registers; reset wins over a data strobe in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Register-file port drive
  always_comb begin
    bus.writeEnable  = we_q;
    bus.writeAddress = waddr_q;
    bus.dataIn       = wdata_q;
  end

endmodule

// File: tb/tb_mips_cpu_writeback.sv
// tb/tb_mips_cpu_writeback.sv - directed self-checking bench for mips_cpu_writeback
module tb_mips_cpu_writeback;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mips_cpu_writeback_if wb ();

  mips_cpu_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue a load, return data after 'lat' cycles of stall, check the commit
  task automatic do_load(input string tag, input logic [4:0] dest, input logic [2:0] op,
                         input logic [1:0] off, input logic [31:0] merge,
                         input logic [31:0] data, input int lat, input logic [31:0] exp);
    wb.load_valid  = 1'b1;
    wb.load_dest   = dest;
    wb.load_op     = op;
    wb.load_offset = off;
    wb.load_merge  = merge;
    step();
    wb.load_valid  = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      check({tag, "_stall"}, 32'(wb.stall), 32'd1);
      check({tag, "_pend"},  32'(wb.pending_valid), 32'd1);
      check({tag, "_pdest"}, 32'(wb.pending_dest), 32'(dest));
      check({tag, "_nowe"},  32'(wb.writeEnable), 32'd0);
      if (i == lat) begin
        wb.mem_readdatavalid = 1'b1;
        wb.mem_readdata      = data;
      end
      step();
    end
    wb.mem_readdatavalid = 1'b0;
    check({tag, "_we"},    32'(wb.writeEnable), 32'd1);
    check({tag, "_addr"},  32'(wb.writeAddress), 32'(dest));
    check({tag, "_data"},  wb.dataIn, exp);
    check({tag, "_idle"},  32'(wb.stall), 32'd0);
    step();
    check({tag, "_pulse"}, 32'(wb.writeEnable), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_lwl;
    logic [31:0] exp_lwr;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wb.alu_valid = 1'b0;  wb.alu_dest = 5'd0;  wb.alu_result = 32'd0;
    wb.load_valid = 1'b0; wb.load_dest = 5'd0; wb.load_op = 3'd0;
    wb.load_offset = 2'd0; wb.load_merge = 32'd0;
    wb.mem_readdatavalid = 1'b0; wb.mem_readdata = 32'd0;
    step();
    step();
    check("rst_we",    32'(wb.writeEnable), 32'd0);
    check("rst_addr",  32'(wb.writeAddress), 32'd0);
    check("rst_data",  wb.dataIn, 32'd0);
    check("rst_stall", 32'(wb.stall), 32'd0);
    check("rst_pend",  32'(wb.pending_valid), 32'd0);
    check("rst_pdest", 32'(wb.pending_dest), 32'd0);
    reset = 1'b0;

    // ALU write with one-cycle latency and single-cycle pulse
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd5; wb.alu_result = 32'hDEADBEEF;
    step();
    wb.alu_valid = 1'b0;
    check("alu_we",   32'(wb.writeEnable), 32'd1);
    check("alu_addr", 32'(wb.writeAddress), 32'd5);
    check("alu_data", wb.dataIn, 32'hDEADBEEF);
    step();
    check("alu_pulse", 32'(wb.writeEnable), 32'd0);
    check("alu_hold",  wb.dataIn, 32'hDEADBEEF);

    // sub-word loads
    do_load("lb",  5'd7,  3'b001, 2'd2, 32'd0, 32'h0080FF00, 3, 32'hFFFFFF80);
    do_load("lhu", 5'd8,  3'b100, 2'd2, 32'd0, 32'hABCD1234, 1, 32'h0000ABCD);
    do_load("lh",  5'd9,  3'b011, 2'd0, 32'd0, 32'h00008001, 1, 32'hFFFF8001);
    do_load("lbu", 5'd10, 3'b010, 2'd1, 32'd0, 32'h0080FF00, 2, 32'h000000FF);
    do_load("op7", 5'd11, 3'b111, 2'd3, 32'd0, 32'h12345678, 1, 32'h12345678);

    // ALU and load in the same cycle, then ALU held during WAIT_LOAD
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd3; wb.alu_result = 32'h11;
    wb.load_valid = 1'b1; wb.load_dest = 5'd4; wb.load_op = 3'b000; wb.load_offset = 2'd0;
    step();
    check("dual_we",    32'(wb.writeEnable), 32'd1);
    check("dual_addr",  32'(wb.writeAddress), 32'd3);
    check("dual_data",  wb.dataIn, 32'h11);
    check("dual_stall", 32'(wb.stall), 32'd1);
    check("dual_pdest", 32'(wb.pending_dest), 32'd4);
    wb.alu_dest = 5'd6; wb.alu_result = 32'h99;
    step();
    check("wait_alu_ign", 32'(wb.writeEnable), 32'd0);
    wb.alu_valid = 1'b0; wb.load_valid = 1'b0;
    wb.mem_readdatavalid = 1'b1; wb.mem_readdata = 32'hCAFEF00D;
    step();
    wb.mem_readdatavalid = 1'b0;
    check("dual_ld_we",   32'(wb.writeEnable), 32'd1);
    check("dual_ld_addr", 32'(wb.writeAddress), 32'd4);
    check("dual_ld_data", wb.dataIn, 32'hCAFEF00D);
    step();

    // unaligned word loads
`ifdef MIPS_CPU_WRITEBACK_UNALIGNED_EN
    exp_lwl = 32'hCCDD3344;
    exp_lwr = 32'h11AABBCC;
`else
    exp_lwl = 32'hAABBCCDD;
    exp_lwr = 32'hAABBCCDD;
`endif
    do_load("lwl", 5'd12, 3'b101, 2'd1, 32'h11223344, 32'hAABBCCDD, 1, exp_lwl);
    do_load("lwr", 5'd12, 3'b110, 2'd1, 32'h11223344, 32'hAABBCCDD, 1, exp_lwr);

    // ALU write to $0 is dropped and the port holds its previous values
    wb.alu_valid = 1'b1; wb.alu_dest = 5'd0; wb.alu_result = 32'h55;
    step();
    wb.alu_valid = 1'b0;
    check("r0_alu_we",   32'(wb.writeEnable), 32'd0);
    check("r0_alu_addr", 32'(wb.writeAddress), 32'd12);
    check("r0_alu_data", wb.dataIn, exp_lwr);

    // load to $0 still waits for data but writes nothing
    wb.load_valid = 1'b1; wb.load_dest = 5'd0; wb.load_op = 3'b000;
    step();
    wb.load_valid = 1'b0;
    check("r0_ld_stall", 32'(wb.stall), 32'd1);
    step();
    check("r0_ld_stall2", 32'(wb.stall), 32'd1);
    wb.mem_readdatavalid = 1'b1; wb.mem_readdata = 32'h77;
    step();
    wb.mem_readdatavalid = 1'b0;
    check("r0_ld_we",    32'(wb.writeEnable), 32'd0);
    check("r0_ld_stall3", 32'(wb.stall), 32'd0);

    // read data strobe while idle is ignored
    wb.mem_readdatavalid = 1'b1; wb.mem_readdata = 32'h88;
    step();
    wb.mem_readdatavalid = 1'b0;
    check("idle_rdv_we", 32'(wb.writeEnable), 32'd0);

    // reset while waiting, data strobe in the reset cycle
    wb.load_valid = 1'b1; wb.load_dest = 5'd13; wb.load_op = 3'b000;
    step();
    wb.load_valid = 1'b0;
    check("rstld_stall", 32'(wb.stall), 32'd1);
    reset = 1'b1;
    wb.mem_readdatavalid = 1'b1; wb.mem_readdata = 32'h99;
    step();
    reset = 1'b0;
    wb.mem_readdatavalid = 1'b0;
    check("rstld_we",    32'(wb.writeEnable), 32'd0);
    check("rstld_stall2", 32'(wb.stall), 32'd0);
    check("rstld_pend",  32'(wb.pending_valid), 32'd0);
    check("rstld_pdest", 32'(wb.pending_dest), 32'd0);
    step();
    check("rstld_we2",   32'(wb.writeEnable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_writeback.md
# mips_cpu_writeback

Write-back unit that is the single writer of the register file's write port (`writeEnable`, `writeAddress`, `dataIn`). It accepts ALU results and load requests from the execute/memory stages. It waits for memory read data on a valid-strobe interface. Before committing, it sign/zero-extends or merges the loaded data. It tracks one outstanding load and exposes its destination for hazard logic.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; one clock; all state cleared on the rising edge of `clk` while high.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_dest` in 5: destination register for ALU result.
- `alu_result` in 32: ALU result.
- `load_valid` in 1: load issued this cycle.
- `load_dest` in 5: destination register for load.
- `load_op` in 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR, 111 treated as LW.
- `load_offset` in 2: address bits [1:0] of the load.
- `load_merge` in 32: current contents of `load_dest` (used by LWL/LWR only).
- `mem_readdatavalid` in 1: `mem_readdata` valid this cycle.
- `mem_readdata` in 32: aligned word from memory, little-endian byte lanes.
- `stall` out 1: unit cannot accept `alu_valid`/`load_valid` this cycle.
- `pending_valid` out 1: a load is outstanding.
- `pending_dest` out 5: destination of the outstanding load.
- `writeEnable` out 1: register-file write strobe.
- `writeAddress` out 5: register-file write address.
- `dataIn` out 32: register-file write data.

## Operation
- FSM states: IDLE, WAIT_LOAD. Reset state is IDLE.
- Reset values: all outputs are 0; captured load fields are 0.
- IDLE:
  - `alu_valid=1` registers a write: the next cycle has `writeEnable=1`, `writeAddress=alu_dest`, `dataIn=alu_result`.
  - `load_valid=1` captures `load_dest`, `load_op`, `load_offset` and `load_merge`, then moves to WAIT_LOAD.
  - Both asserted in the same cycle: both are accepted. The ALU write commits next cycle, and the load proceeds.
- WAIT_LOAD:
  - `stall=1`, `pending_valid=1`, `pending_dest`=captured destination.
  - `alu_valid` and `load_valid` are ignored; the producer holds them.
  - On `mem_readdatavalid=1`, the formatted result is registered: the next cycle has `writeEnable=1`, `writeAddress`=captured destination, `dataIn`=formatted data. The state returns to IDLE in that same next cycle, with `stall` already 0.
- `mem_readdatavalid` in IDLE is ignored.
- Destination 0: `writeEnable` is forced to 0 for both ALU and load commits. A load to `$0` still waits for its data.
- `writeEnable` is a one-cycle pulse per commit; `writeAddress`/`dataIn` hold their last values while `writeEnable=0`.
- Load formatting (b = `load_offset`, D = `mem_readdata`):
  - LB/LBU: byte D[8b+7:8b], sign-/zero-extended to 32 bits.
  - LH/LHU: halfword D[16·b[1]+15:16·b[1]], sign-/zero-extended. b[0] is ignored.
  - LW: D.
  - LWL: (D << 8·(3−b)) OR (`load_merge` AND low-mask of 8·(3−b) bits).
  - LWR: (D >> 8·b) OR (`load_merge` AND high-mask of 8·b bits).
- Reset mid-load: the outstanding load is discarded, the state goes to IDLE, and no write is issued even if `mem_readdatavalid` arrives in the reset cycle.

## Timing
- ALU latency: 1 cycle from `alu_valid` to `writeEnable`.
- Load latency: 1 cycle after `mem_readdatavalid`. The minimum is 2 cycles from `load_valid`, when data is valid the cycle after issue.
- `stall`, `pending_valid` and `pending_dest` are registered outputs. `stall` rises the cycle after `load_valid` is accepted.
- One load outstanding at most; back-to-back loads are issued after `stall` deasserts.

## Configuration
- `MIPS_CPU_WRITEBACK_UNALIGNED_EN` defined: LWL/LWR merge formatting is compiled in as described above.
- Not defined: `load_op` 101/110 format as LW. `load_merge` is unused, and no merge logic is built.

## Test plan
- Reset, then `alu_valid=1`, `alu_dest=5`, `alu_result=32'hDEADBEEF` → next cycle `writeEnable=1`, `writeAddress=5`, `dataIn=32'hDEADBEEF`, with a single-cycle pulse.
- LB, `load_offset=2`, `mem_readdata=32'h0080FF00` returned 3 cycles later → `dataIn=32'hFFFFFF80`. `stall`/`pending_valid` are high for 3 cycles, and `pending_dest` equals `load_dest`.
- LHU, offset 2, data `32'hABCD1234` → `32'h0000ABCD`. LH, offset 0, data `32'h00008001` → `32'hFFFF8001`.
- Same-cycle `alu_valid` (dest 3, `32'h11`) and LW (dest 4) → write of 3 next cycle, then write of 4 the cycle after `mem_readdatavalid`. `alu_valid` asserted during WAIT_LOAD produces no write.
- With `MIPS_CPU_WRITEBACK_UNALIGNED_EN`:
  - LWL, offset 1, D=`32'hAABBCCDD`, merge `32'h11223344` → `32'hCCDD3344`.
  - LWR, offset 1, same operands → `32'h11AABBCC`.
  - Without the macro, both → `32'hAABBCCDD`.
- `alu_dest=0` → no `writeEnable`. Reset asserted while in WAIT_LOAD, with `mem_readdatavalid=1` in the same cycle → no write, and `stall=0` the next cycle.
